// File: rtl/uart_tx.sv
// uart_tx: byte FIFO feeding an 8N1 serialiser; define UART_TX_PARITY_EN for 8E1 frames.
// tx_o is registered from the current FSM state, so the line trails the state by one cycle.
module uart_tx #(
    parameter int TICKS_PER_BIT = 32,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       stb_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       tx_o,
    output logic [2:0] state_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TICKS_PER_BIT);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] LAST_TICK  = TW'(TICKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t        state, state_next;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic [TW-1:0] tick, tick_next;
    logic [2:0]    bit_cnt, bit_next;
    logic [7:0]    shift, shift_next;
    logic          tx_next, push, pop, tick_last;
`ifdef UART_TX_PARITY_EN
    logic          parity, parity_next;
`endif

    // Handshake: a byte transfers on a rising edge where stb_i && ready_o (reset wins);
    // ready_o reflects the pre-edge count, so a push on a full FIFO is dropped even if a pop coincides.
    assign push      = stb_i && ready_o && !rst_i;
    assign tick_last = (tick == LAST_TICK);
    assign state_o   = state;

    always_comb begin
        unique case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_comb begin
        state_next  = state;
        tick_next   = tick + 1'b1;
        bit_next    = bit_cnt;
        shift_next  = shift;
        pop         = 1'b0;
        tx_next     = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_next = parity;
`endif
        case (state)
            S_IDLE: begin
                tick_next = '0;
                if (count != '0) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    bit_next   = '0;
                    state_next = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^mem[rd_ptr];
`endif
                end
            end
            S_START: begin
                tx_next = 1'b0;
                if (tick_last) begin
                    tick_next  = '0;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                tx_next = shift[0];
                if (tick_last) begin
                    tick_next  = '0;
                    shift_next = shift >> 1;
                    bit_next   = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx_next = parity;
                if (tick_last) begin
                    tick_next  = '0;
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick_last) begin
                    tick_next = '0;
                    // A queued byte starts its start bit on the very next cycle.
                    if (count != '0) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        bit_next   = '0;
                        state_next = S_START;
`ifdef UART_TX_PARITY_EN
                        parity_next = ^mem[rd_ptr];
`endif
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                tick_next  = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            tick    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx_o    <= 1'b1;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            count   <= count_next;
            tick    <= tick_next;
            bit_cnt <= bit_next;
            shift   <= shift_next;
            tx_o    <= tx_next;
            ready_o <= (count_next != FULL_COUNT);
            busy_o  <= (state != S_IDLE) || (count != '0);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
`ifdef UART_TX_PARITY_EN
            parity  <= parity_next;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: line-level waveform model, frame decoder, directed and random traffic.
module tb_uart_tx;
  localparam int TPB   = 32;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * TPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stb = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, busy, tx;
  logic [2:0] dbg_state;

  uart_tx #(.TICKS_PER_BIT(TPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .stb_i   (stb),
    .data_i  (data),
    .ready_o (ready),
    .busy_o  (busy),
    .tx_o    (tx),
    .state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a byte queue, a frame-remaining counter and the queued line levels.
  logic [7:0] m_fifo[$];
  logic       m_line[$];
  logic [7:0] exp_q[$];
  int         m_left   = 0;
  bit         m_popped = 0;
  logic       exp_tx = 1'b1, exp_ready = 1'b1, exp_busy = 1'b0;

  always @(posedge clk) begin : model
    logic [7:0] b;
    logic       lv;
    int         pre_size;
    bit         pre_active, do_pop;
    m_popped = 0;
    if (rst) begin
      m_fifo.delete();
      m_line.delete();
      exp_q.delete();
      m_left    = 0;
      exp_tx    = 1'b1;
      exp_ready = 1'b1;
      exp_busy  = 1'b0;
    end else begin
      pre_size   = m_fifo.size();
      pre_active = (m_left != 0);
      exp_busy   = pre_active || (pre_size != 0);
      exp_tx     = (m_line.size() != 0) ? m_line.pop_front() : 1'b1;
      do_pop = 0;
      if (!pre_active) begin
        if (pre_size != 0) do_pop = 1;
      end else if (m_left == 1) begin
        m_left = 0;
        if (pre_size != 0) do_pop = 1;
      end else begin
        m_left--;
      end
      if (do_pop) begin
        b = m_fifo.pop_front();
        exp_q.push_back(b);
        for (int k = 0; k < NBITS; k++) begin
          if (k == 0) lv = 1'b0;
          else if (k <= 8) lv = b[k-1];
          else if (NBITS == 11 && k == 9) lv = ^b;
          else lv = 1'b1;
          repeat (TPB) m_line.push_back(lv);
        end
        m_left   = FRAME;
        m_popped = 1;
      end
      if (stb && pre_size < DEPTH) m_fifo.push_back(data);
      exp_ready = (m_fifo.size() < DEPTH);
    end
  end

  // Per-cycle line/handshake comparison against the model.
  bit checking = 0;
  always @(negedge clk) begin
    if (checking) begin
      check("tx_line", tx, exp_tx);
      check("ready", ready, exp_ready);
      check("busy", busy, exp_busy);
    end
  end

  // Frame decoder sampling at bit centres; scoreboard against exp_q.
  int          rx_cnt = -1;
  logic [10:0] rx_bits = '0;
  int          rx_frames = 0;
  int          rx_55 = 0;

  always @(negedge clk) begin : decoder
    logic [7:0]  rb;
    logic [31:0] e;
    int          idx;
    if (rst) begin
      rx_cnt = -1;
    end else begin
      if (rx_cnt < 0) begin
        if (tx === 1'b0) rx_cnt = 0;
      end else begin
        rx_cnt++;
      end
      if (rx_cnt >= 0 && (rx_cnt % TPB) == TPB / 2) begin
        idx = rx_cnt / TPB;
        rx_bits[idx] = tx;
        if (idx == NBITS - 1) begin
          rb = rx_bits[8:1];
          e  = (exp_q.size() != 0) ? {24'h0, exp_q.pop_front()} : 'x;
          check("rx_start", rx_bits[0], 1'b0);
          check("rx_byte", rb, e);
`ifdef UART_TX_PARITY_EN
          check("rx_parity", rx_bits[9], ^rb);
`endif
          check("rx_stop", rx_bits[NBITS-1], 1'b1);
          rx_frames++;
          if (rb == 8'h55) rx_55++;
          rx_cnt = -1;
        end
      end
    end
  end

  // Driver tasks: called just after a falling edge, return just after the next one.
  task automatic drive_byte(input logic [7:0] b);
    stb  = 1'b1;
    data = b;
    @(negedge clk);
    stb  = 1'b0;
    data = 8'($urandom);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((m_left != 0 || m_fifo.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("idle_timeout", n < limit, 1'b1);
  endtask

  int f0;
  int n;

  initial begin
    repeat (2) @(negedge clk);
    checking = 1;
    check("rst_tx", tx, 1'b1);
    check("rst_ready", ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // single byte and start-bit latency
    f0 = rx_frames;
    drive_byte(8'hA5);
    check("lat_e0_tx", tx, 1'b1);
    @(negedge clk);
    check("lat_e1_tx", tx, 1'b1);
    @(negedge clk);
    check("lat_e2_tx", tx, 1'b0);
    check("lat_busy", busy, 1'b1);
    wait_idle(2 * FRAME);
    check("single_busy_low", busy, 1'b0);
    check("single_frames", rx_frames - f0, 1);

    // back-to-back fill, drop on full, push on full with simultaneous pop
    f0 = rx_frames;
    rx_55 = 0;
    drive_byte(8'h01);
    drive_byte(8'h02);
    drive_byte(8'h03);
    drive_byte(8'h04);
    drive_byte(8'h05);
    check("ready_full", ready, 1'b0);
    drive_byte(8'hFF);
    stb  = 1'b1;
    data = 8'h55;
    n = 0;
    while (!m_popped && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    stb = 1'b0;
    check("full_pop_timeout", n < 2 * FRAME, 1'b1);
    check("ready_after_pop", ready, 1'b1);
    wait_idle(8 * FRAME);
    check("b2b_frames", rx_frames - f0, 5);
    check("dropped_55", rx_55, 0);

    // reset mid-frame
    f0 = rx_frames;
    drive_byte(8'hF0);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rmid_tx", tx, 1'b1);
    check("rmid_busy", busy, 1'b0);
    check("rmid_ready", ready, 1'b1);
    repeat (FRAME) @(negedge clk);
    check("rmid_no_frame", rx_frames - f0, 0);
    drive_byte(8'h0F);
    wait_idle(2 * FRAME);
    check("rmid_new_frame", rx_frames - f0, 1);

    // parity-sensitive bytes
    f0 = rx_frames;
    drive_byte(8'hA5);
    drive_byte(8'h07);
    wait_idle(4 * FRAME);
    check("par_frames", rx_frames - f0, 2);

    // randomized bursts and gaps
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) drive_byte(8'($urandom));
      repeat ($urandom_range(0, FRAME)) @(negedge clk);
    end
    wait_idle(10 * FRAME);
    check("exp_q_drained", exp_q.size(), 0);
    check("final_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
